// File: rtl/uart_rx_port_if.sv
// Bundles the serial line, consumer acknowledge and receiver status into one port.
interface uart_rx_port_if;
  logic       rx;
  logic       rd_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       has_data;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  // Receiver side
  modport slave (
    input  rx,
    input  rd_ack,
    output data_out,
    output data_valid,
    output has_data,
    output frame_err,
    output overrun,
    output busy
  );

  // Line driver / consumer side
  modport master (
    output rx,
    output rd_ack,
    input  data_out,
    input  data_valid,
    input  has_data,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 serial receiver feeding the core's io_in port. Holds the last good byte
// and reports new-data, framing-error and overrun status.
module uart_rx_port #(
  parameter int unsigned CLK_DIV    = 16,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input logic           clk,
  input logic           reset,
  uart_rx_port_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            has_q, has_d;
  logic            ovr_q, ovr_d;
  logic            rx_meta_q, rx_s_q;

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= IDLE_LEVEL;
      rx_s_q    <= IDLE_LEVEL;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      has_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      has_q   <= has_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: frame sequencing, byte capture and status flag updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    has_d   = has_q;
    ovr_d   = ovr_q;

    // Acknowledge clears flags; a byte completing in this cycle overrides below.
    if (bus.rd_ack) begin
      has_d = 1'b0;
      ovr_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_s_q != IDLE_LEVEL) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s_q != IDLE_LEVEL) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            // Line bounced back: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          // Return mid-stop-bit so a back-to-back start edge is not missed.
          state_d = StIdle;
          if (rx_s_q == IDLE_LEVEL) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            has_d   = 1'b1;
            if (has_q && !bus.rd_ack) begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.has_data   = has_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: expected bytes are queued when a frame is
// sent and popped by a monitor whenever data_valid pulses.
module tb_uart_rx_port;
  localparam int unsigned ClkDiv = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_port_if bus ();

  uart_rx_port #(
    .CLK_DIV   (ClkDiv),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int last_fall_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every data_valid pops one expected byte
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.data_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_unexpected: got data_valid with data %h, required no pulse",
                   bus.data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.data_out !== mon_exp)
            $display("FAIL scoreboard_data: got %h required %h", bus.data_out, mon_exp);
          else pass_cnt++;
        end
      end
      if (bus.frame_err) ferr_cnt++;
    end
  end

  // Sends one frame; optionally pulses rd_ack late in the stop bit (after data_valid)
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input bit ack_in_stop);
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    last_fall_cyc = cyc;
    repeat (ClkDiv) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (ClkDiv) @(posedge clk);
      #1;
    end
    bus.rx = stop_lvl;
    if (ack_in_stop) begin
      repeat (13) @(posedge clk);
      #1;
      bus.rd_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end else begin
      repeat (ClkDiv) @(posedge clk);
      #1;
    end
    bus.rx = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.rd_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.rd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.rd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.data_out !== 8'h00) $display("FAIL reset_data: got %h required 00", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", bus.data_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b0) $display("FAIL reset_has_data: got %b required 0", bus.has_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b required 0", bus.frame_err);
    else pass_cnt++;
    total_cnt++;
    if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b required 0", bus.overrun);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy);
    else pass_cnt++;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int v0, f0, lat;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    lat = last_valid_cyc - last_fall_cyc;
    total_cnt++;
    if (valid_cnt - v0 != 1) $display("FAIL basic_pulses: got %0d required 1", valid_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (lat < 154 || lat > 156) $display("FAIL basic_latency: got %0d required 155+/-1", lat);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'hA5) $display("FAIL basic_data: got %h required a5", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b1) $display("FAIL basic_has_data: got %b required 1", bus.has_data);
    else pass_cnt++;
    total_cnt++;
    if (ferr_cnt != f0) $display("FAIL basic_ferr: got %0d pulses required 0", ferr_cnt - f0);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy: got %b required 0", bus.busy);
    else pass_cnt++;
    pulse_ack();
    total_cnt++;
    if (bus.has_data !== 1'b0) $display("FAIL basic_ack_clear: got %b required 0", bus.has_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'hC3, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (valid_cnt - v0 != 2) $display("FAIL b2b_pulses: got %0d required 2", valid_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'hC3) $display("FAIL b2b_data: got %h required c3", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.overrun !== 1'b0) $display("FAIL b2b_overrun: got %b required 0", bus.overrun);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b1) $display("FAIL b2b_has_data: got %b required 1", bus.has_data);
    else pass_cnt++;
    pulse_ack();
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.data_out !== 8'h22) $display("FAIL ovr_data: got %h required 22", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b1) $display("FAIL ovr_has_data: got %b required 1", bus.has_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.overrun !== 1'b1) $display("FAIL ovr_flag: got %b required 1", bus.overrun);
    else pass_cnt++;
    pulse_ack();
    total_cnt++;
    if (bus.has_data !== 1'b0) $display("FAIL ovr_ack_has: got %b required 0", bus.has_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.overrun !== 1'b0) $display("FAIL ovr_ack_flag: got %b required 0", bus.overrun);
    else pass_cnt++;
  endtask

  task automatic test_framing();
    int v0, f0;
    do_reset();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (3 * ClkDiv) @(posedge clk);
    #1;
    total_cnt++;
    if (ferr_cnt - f0 != 1) $display("FAIL frame_pulses: got %0d required 1", ferr_cnt - f0);
    else pass_cnt++;
    total_cnt++;
    if (valid_cnt != v0) $display("FAIL frame_valid: got %0d required 0", valid_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h00) $display("FAIL frame_data: got %h required 00", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b0) $display("FAIL frame_has_data: got %b required 0", bus.has_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL frame_busy: got %b required 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL glitch_busy: got %b required 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (valid_cnt != v0 || ferr_cnt != f0)
      $display("FAIL glitch_pulses: got %0d valid %0d ferr required 0 0",
               valid_cnt - v0, ferr_cnt - f0);
    else pass_cnt++;
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.data_out !== 8'h0F) $display("FAIL glitch_next_data: got %h required 0f", bus.data_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int v0;
    b = 8'h99;
    v0 = valid_cnt;
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (ClkDiv) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.rx = b[i];
      repeat (ClkDiv) @(posedge clk);
      #1;
    end
    bus.rx = b[3];
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", bus.busy);
    else pass_cnt++;
    reset = 1'b1;
    bus.rx = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b0) $display("FAIL midrst_has_data: got %b required 0", bus.has_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h00) $display("FAIL midrst_data: got %h required 00", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0)
      $display("FAIL midrst_pulses: got valid %b ferr %b ovr %b required 0 0 0",
               bus.data_valid, bus.frame_err, bus.overrun);
    else pass_cnt++;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (valid_cnt != v0) $display("FAIL midrst_no_valid: got %0d required 0", valid_cnt - v0);
    else pass_cnt++;
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.data_out !== 8'hFF) $display("FAIL midrst_next_data: got %h required ff", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.has_data !== 1'b1) $display("FAIL midrst_next_has: got %b required 1", bus.has_data);
    else pass_cnt++;
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.rd_ack = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Serial receiver that feeds the microprocessor's 8-bit `io_in` port: it deserialises an asynchronous 8N1 line into a held byte that the `IN` instruction reads.
- Provides status flags (byte available, framing error, overrun) so a poll loop or a later status port can tell a new byte from a stale one.
- Sits directly upstream of the core; `data_out` connects to `io_in`.

Parameters:
- CLK_DIV, 16, clocks per serial bit period; must be even and >= 4.
- IDLE_LEVEL, 1'b1, line level when idle and during the stop bit.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line
- rd_ack  input  1  one-cycle pulse: the consumer has taken data_out; clears has_data and overrun
- data_out  output  8  last correctly framed byte; held stable until the next good byte; drives io_in
- data_valid  output  1  one-cycle pulse when data_out is updated
- has_data  output  1  sticky: an unread byte is present
- frame_err  output  1  one-cycle pulse: the stop bit was sampled low
- overrun  output  1  sticky: a good byte arrived while has_data=1
- busy  output  1  high in every state except IDLE

Behaviour:
- **Clock and reset:** one clock domain. Reset is synchronous and active-high.
- **Reset values:** data_out=8'h00; data_valid=0; has_data=0; frame_err=0; overrun=0; busy=0. State=IDLE, counters=0, synchroniser flops=IDLE_LEVEL.
- **Reset mid-frame:** aborts the frame. No valid or error pulse is produced.
- **Synchroniser:** rx passes through a 2-flop synchroniser; rx_s is the second flop. All decisions use rx_s only.
- **Counters:** bit-period counter of width clog2(CLK_DIV); 3-bit bit index.
- **IDLE:** when rx_s != IDLE_LEVEL, go to START with counter=0.
- **START:** count up. At counter==CLK_DIV/2-1, sample rx_s:
  - still active → go to DATA, counter=0, bit index=0;
  - back at IDLE_LEVEL → false start: return to IDLE, no pulse.
- **DATA:** at counter==CLK_DIV-1, sample rx_s into the shift register.
  - LSB first; bit index i goes to bit i.
  - Reset counter to 0.
  - After bit index 7, go to STOP; otherwise increment the bit index.
- **STOP:** at counter==CLK_DIV-1, sample rx_s, then return to IDLE (mid-stop-bit) in both cases below.
  - rx_s==IDLE_LEVEL → data_out<=shift register; data_valid=1 for one cycle; has_data<=1.
  - rx_s!=IDLE_LEVEL → frame_err=1 for one cycle; data_out and has_data unchanged.
- **Overrun:** on a good byte with has_data already 1 and no rd_ack in the same cycle, set overrun. data_out is still overwritten with the new byte.
- **rd_ack:**
  - Clears has_data and overrun on the next edge.
  - If rd_ack and a good-byte completion coincide, the completion wins: has_data=1, overrun not set.
  - rd_ack while has_data=0 has no effect.
- **Timing:** all samples land at mid-bit. Latency from the rx falling edge to data_valid is 2 (sync) + 1 (IDLE detect) + CLK_DIV/2 + 9*CLK_DIV cycles, +/-1 cycle for edge phase. This is 155 cycles for CLK_DIV=16.
- **Frame-to-frame:** back-to-back frames need no idle gap beyond the second half of the stop bit; a new start edge is accepted immediately in IDLE.
- **Break condition:** a line held low indefinitely produces one frame_err per frame time and no data_valid.

Test Plan:
- **Basic byte:** reset, CLK_DIV=16, send 0xA5 (start, bits 1,0,1,0,0,1,0,1 LSB first, stop) → data_out=0xA5; data_valid exactly one pulse 155+/-1 cycles after the falling edge; has_data=1; frame_err=0; busy returns to 0.
- **Back-to-back with ack:** send 0x3C then 0xC3 with no gap, pulse rd_ack between them → two data_valid pulses; final data_out=0xC3; overrun=0.
- **Overrun:** send 0x11 then 0x22, no rd_ack → data_out=0x22; has_data=1; overrun=1. A following rd_ack clears both flags on the next edge.
- **Framing error:** send 0x55 with the stop bit driven low → frame_err single pulse; no data_valid; data_out keeps its previous value (0x00 after reset).
- **Glitch rejection:** drive rx low for 4 cycles, then high → state returns to IDLE; busy drops; no pulses. A subsequent 0x0F is received correctly.
- **Reset mid-frame:** assert reset during DATA bit 3 → all outputs at reset values next cycle. A subsequent 0xFF is received correctly.
